// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: PC generation, single-outstanding imem requests and a small
// fetch buffer feeding IF/ID. Optional macro IFU_MISALIGN_CHECK_EN adds fetch_misalign.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        checkpre_flush,
    input  logic [31:0] redirect_pc,
    input  logic        feedforward_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_addr,
    output logic        ifid_valid
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int              PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]     ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               drop_q, drop_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]        mem_q [FIFO_DEPTH];
    logic [63:0]        mem_d [FIFO_DEPTH];

    logic               flush_s;
    logic               push_s;
    logic               pop_s;
    logic               block_s;
    logic               not_empty_s;
    logic [31:0]        target_s;

    assign flush_s     = checkpre_flush;
    assign target_s    = redirect_pc & ALIGN_MASK;
    assign not_empty_s = (count_q != {CNT_W{1'b0}});
    assign push_s      = (state_q == S_WAIT) && imem_rvalid && !drop_q && !flush_s;
    assign pop_s       = not_empty_s && !feedforward_stall && !flush_s;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // A misaligned redirect latches the error and blocks new requests until an aligned one.
    always_comb begin
        if (flush_s) begin
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            misalign_d = misalign_q;
        end
    end

    assign block_s        = misalign_d;
    assign fetch_misalign = misalign_q;
`else
    assign block_s = 1'b0;
`endif

    // Fetch buffer next state: flush empties it, otherwise push at tail and pop at head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {imem_rdata, imem_addr_q};
            end else begin
                mem_d = mem_q;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Request FSM: the outstanding request always owns one buffer slot, so pushes never overflow.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (flush_s) begin
                    pc_d    = target_s;
                    state_d = block_s ? S_IDLE : S_REQ;
                end else if (!block_s && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush_s) begin
                    pc_d   = target_s;
                    drop_d = 1'b1;
                end else if (imem_gnt && !drop_q) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = (!block_s && (count_d < DEPTH_C)) ? S_REQ : S_IDLE;
                end else begin
                    drop_d  = flush_s ? 1'b1 : drop_q;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // The request address is loaded only on entry to REQ, so a held request never changes.
    always_comb begin
        imem_req_d = (state_d == S_REQ);
        if ((state_d == S_REQ) && (state_q != S_REQ)) begin
            imem_addr_d = pc_d;
        end else begin
            imem_addr_d = imem_addr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            count_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 64'h0;
            end
`ifdef IFU_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
`ifdef IFU_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign ifid_valid = not_empty_s;
    assign ifid_instr = not_empty_s ? mem_q[rd_ptr_q][63:32] : NOP_INSTR;
    assign ifid_addr  = not_empty_s ? mem_q[rd_ptr_q][31:0]  : 32'h0000_0000;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small memory responder plus a linear checked sequence.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        checkpre_flush;
    logic [31:0] redirect_pc;
    logic        feedforward_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_addr;
    logic        ifid_valid;

    int   checks   = 0;
    int   failures = 0;
    logic gnt_en;
    int   rv_lat;

    ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .checkpre_flush    (checkpre_flush),
        .redirect_pc       (redirect_pc),
        .feedforward_stall (feedforward_stall),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .ifid_instr        (ifid_instr),
        .ifid_addr         (ifid_addr),
        .ifid_valid        (ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: grant when enabled, answer rv_lat cycles after the grant cycle ends.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend        = 1'b0;
        paddr       = 32'h0;
        cnt         = 0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = rv_lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            imem_gnt = imem_req && gnt_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge where reset is released (cycle n0).
    task automatic do_reset();
        rst               = 1'b1;
        checkpre_flush    = 1'b0;
        feedforward_stall = 1'b0;
        redirect_pc       = 32'h0;
        gnt_en            = 1'b1;
        rv_lat            = 0;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        checkpre_flush    = 1'b0;
        feedforward_stall = 1'b0;
        redirect_pc       = 32'h0;
        gnt_en            = 1'b1;
        rv_lat            = 0;
        tick(2);
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_iaddr", imem_addr,           32'h0000_0000);
        chk("rst_instr", ifid_instr,          32'h0000_0013);
        chk("rst_faddr", ifid_addr,           32'h0000_0000);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);

        // In-order fetch, then flush to 0x100 while waiting on the 0x8 response.
        rst = 1'b0;
        tick(1);
        chk("seq_req0",   {31'd0, imem_req}, 32'd1);
        chk("seq_iaddr0", imem_addr,         32'h0000_0000);
        tick(2);
        chk("seq_valid0", {31'd0, ifid_valid}, 32'd1);
        chk("seq_faddr0", ifid_addr,           32'h0000_0000);
        chk("seq_instr0", ifid_instr,          32'hC0DE_0000);
        chk("seq_iaddr4", imem_addr,           32'h0000_0004);
        tick(1);
        rv_lat = 2;
        tick(1);
        chk("seq_faddr4", ifid_addr, 32'h0000_0004);
        chk("seq_iaddr8", imem_addr, 32'h0000_0008);
        tick(1);
        chk("fl_pre_valid", {31'd0, ifid_valid}, 32'd0);
        checkpre_flush = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick(1);
        checkpre_flush = 1'b0;
        tick(1);
        chk("fl_drop_valid", {31'd0, ifid_valid}, 32'd0);
        rv_lat = 0;
        tick(1);
        chk("fl_req",       {31'd0, imem_req}, 32'd1);
        chk("fl_iaddr",     imem_addr,         32'h0000_0100);
        chk("fl_mid_valid", {31'd0, ifid_valid}, 32'd0);
        tick(2);
        chk("fl_valid", {31'd0, ifid_valid}, 32'd1);
        chk("fl_faddr", ifid_addr,           32'h0000_0100);
        chk("fl_instr", ifid_instr,          32'hC0DE_0100);

        // Stall for five cycles while the buffer fills, then drain.
        do_reset();
        feedforward_stall = 1'b1;
        tick(3);
        chk("st_valid0", {31'd0, ifid_valid}, 32'd1);
        chk("st_faddr0", ifid_addr,           32'h0000_0000);
        tick(1);
        chk("st_faddr1", ifid_addr, 32'h0000_0000);
        tick(1);
        chk("st_faddr2", ifid_addr,         32'h0000_0000);
        chk("st_instr2", ifid_instr,        32'hC0DE_0000);
        chk("st_req_off", {31'd0, imem_req}, 32'd0);
        feedforward_stall = 1'b0;
        tick(1);
        chk("st_faddr4", ifid_addr,          32'h0000_0004);
        chk("st_req_idle", {31'd0, imem_req}, 32'd0);
        tick(1);
        chk("st_gap_valid", {31'd0, ifid_valid}, 32'd0);
        chk("st_iaddr8",    imem_addr,           32'h0000_0008);
        tick(2);
        chk("st_faddr8", ifid_addr, 32'h0000_0008);

        // Flush to 0x200 while the request is held un-granted for three cycles.
        do_reset();
        gnt_en = 1'b0;
        tick(1);
        chk("hold_req0", {31'd0, imem_req}, 32'd1);
        checkpre_flush = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick(1);
        checkpre_flush = 1'b0;
        chk("hold_iaddr1", imem_addr, 32'h0000_0000);
        tick(1);
        chk("hold_iaddr2", imem_addr, 32'h0000_0000);
        gnt_en = 1'b1;
        tick(1);
        chk("hold_iaddr3", imem_addr,        32'h0000_0000);
        chk("hold_req3",  {31'd0, imem_req}, 32'd1);
        tick(1);
        chk("hold_wait_valid", {31'd0, ifid_valid}, 32'd0);
        tick(1);
        chk("hold_new_req",   {31'd0, imem_req}, 32'd1);
        chk("hold_new_iaddr", imem_addr,         32'h0000_0200);
        tick(2);
        chk("hold_faddr", ifid_addr,  32'h0000_0200);
        chk("hold_instr", ifid_instr, 32'hC0DE_0200);

        // Flush together with stall on a full buffer.
        do_reset();
        feedforward_stall = 1'b1;
        tick(5);
        chk("fs_full_valid", {31'd0, ifid_valid}, 32'd1);
        checkpre_flush = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick(1);
        checkpre_flush    = 1'b0;
        feedforward_stall = 1'b0;
        chk("fs_valid", {31'd0, ifid_valid}, 32'd0);
        chk("fs_instr", ifid_instr,          32'h0000_0013);
        chk("fs_faddr", ifid_addr,           32'h0000_0000);
        chk("fs_iaddr", imem_addr,           32'h0000_0300);

        // Reset while a response is outstanding; the late response must be ignored.
        do_reset();
        feedforward_stall = 1'b1;
        tick(2);
        rv_lat = 2;
        tick(1);
        chk("rw_valid", {31'd0, ifid_valid}, 32'd1);
        tick(1);
        chk("rw_wait_req", {31'd0, imem_req}, 32'd0);
        rst               = 1'b1;
        feedforward_stall = 1'b0;
        rv_lat            = 0;
        #1;
        chk("rw_rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rw_rst_instr", ifid_instr,          32'h0000_0013);
        chk("rw_rst_iaddr", imem_addr,           32'h0000_0000);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rw_req",   {31'd0, imem_req}, 32'd1);
        chk("rw_iaddr", imem_addr,         32'h0000_0000);
        tick(1);
        chk("rw_late_ignored", {31'd0, ifid_valid}, 32'd0);
        tick(1);
        chk("rw_faddr", ifid_addr,  32'h0000_0000);
        chk("rw_instr", ifid_instr, 32'hC0DE_0000);

        // Unaligned redirect near the top of the address space: low bits masked, PC wraps.
        do_reset();
        checkpre_flush = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick(1);
        checkpre_flush = 1'b0;
        chk("wrap_iaddr0", imem_addr, 32'hFFFF_FFFC);
        tick(2);
        chk("wrap_iaddr1", imem_addr,  32'h0000_0000);
        chk("wrap_faddr",  ifid_addr,  32'hFFFF_FFFC);
        chk("wrap_instr",  ifid_instr, 32'hC0DE_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
